// File: rtl/bcd_char_pkg.sv
// Shared types and constants for the BCD-to-ASCII character serialiser.
package bcd_char_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    TRAIL = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int          NUM_DIGITS = 5;
  localparam int          BCD_W      = 19;
  localparam int          IDX_W      = 3;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_BAD  = 8'h3F;

endpackage

// File: rtl/bcd_digit_to_ascii.sv
// Combinational BCD digit to ASCII mapping; non-decimal codes become '?'.
module bcd_digit_to_ascii
  import bcd_char_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  // Map 0..9 onto '0'..'9', anything else onto '?'
  always_comb begin
    ascii = ASCII_BAD;
    if (digit <= 4'd9) begin
      ascii = ASCII_ZERO + {4'h0, digit};
    end else begin
      ascii = ASCII_BAD;
    end
  end

endmodule

// File: rtl/bcd_char_ser.sv
// Serialises a captured 5-digit BCD value MS digit first into a character FIFO.
// Optional macro BCD_CHAR_SER_LZ_SUPPRESS_EN drops leading zero digits.
module bcd_char_ser
  import bcd_char_pkg::*;
#(
  parameter bit         TRAIL_ON   = 1'b1,
  parameter logic [7:0] TRAIL_CHAR = 8'h20
) (
  input  logic             clk_rx,
  input  logic             rst_clk_rx_n,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd_in,
  output logic [7:0]       char_data,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s, start_idx_s;
  logic [BCD_W-1:0] shadow_r, shadow_s;
  logic [3:0]       digit_s;
  logic [7:0]       ascii_s;
  logic [7:0]       char_data_r, char_data_s;
  logic             char_valid_r, char_valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             xfer_s;

  // First digit position to emit for a freshly captured value
  always_comb begin
`ifdef BCD_CHAR_SER_LZ_SUPPRESS_EN
    start_idx_s = 3'd0;
    if (bcd_in[18:16] != 3'd0) begin
      start_idx_s = 3'd4;
    end else if (bcd_in[15:12] != 4'd0) begin
      start_idx_s = 3'd3;
    end else if (bcd_in[11:8] != 4'd0) begin
      start_idx_s = 3'd2;
    end else if (bcd_in[7:4] != 4'd0) begin
      start_idx_s = 3'd1;
    end else begin
      start_idx_s = 3'd0;
    end
`else
    start_idx_s = TOP_IDX;
`endif
  end

  // Next-state, index and shadow update
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    shadow_s = shadow_r;
    xfer_s   = char_valid_r & char_ready;
    case (state_r)
      IDLE: begin
        if (start) begin
          shadow_s = bcd_in;
          idx_s    = start_idx_s;
          state_s  = SEND;
        end else begin
          state_s  = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && (idx_r != 3'd0)) begin
          idx_s = idx_r - 3'd1;
        end else if (xfer_s) begin
          if (TRAIL_ON) begin
            state_s = TRAIL;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = SEND;
        end
      end
      TRAIL: begin
        if (xfer_s) begin
          state_s = FIN;
        end else begin
          state_s = TRAIL;
        end
      end
      FIN: begin
        state_s = IDLE;
        idx_s   = TOP_IDX;
      end
      default: begin
        state_s = IDLE;
        idx_s   = TOP_IDX;
      end
    endcase
  end

  // Digit selected by the next index so the character can be registered
  always_comb begin
    case (idx_s)
      3'd4:    digit_s = {1'b0, shadow_s[18:16]};
      3'd3:    digit_s = shadow_s[15:12];
      3'd2:    digit_s = shadow_s[11:8];
      3'd1:    digit_s = shadow_s[7:4];
      3'd0:    digit_s = shadow_s[3:0];
      default: digit_s = 4'h0;
    endcase
  end

  bcd_digit_to_ascii u_digit_to_ascii (
    .digit (digit_s),
    .ascii (ascii_s)
  );

  // Output values for the upcoming state; stalls leave everything unchanged
  always_comb begin
    char_data_s  = 8'h00;
    char_valid_s = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    case (state_s)
      SEND: begin
        char_data_s  = ascii_s;
        char_valid_s = 1'b1;
        busy_s       = 1'b1;
      end
      TRAIL: begin
        char_data_s  = TRAIL_CHAR;
        char_valid_s = 1'b1;
        busy_s       = 1'b1;
      end
      FIN: begin
        done_s = 1'b1;
      end
      default: begin
        char_data_s = 8'h00;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      state_r      <= IDLE;
      idx_r        <= TOP_IDX;
      shadow_r     <= {BCD_W{1'b0}};
      char_data_r  <= 8'h00;
      char_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      shadow_r     <= shadow_s;
      char_data_r  <= char_data_s;
      char_valid_r <= char_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign char_data  = char_data_r;
  assign char_valid = char_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_bcd_char_ser.sv
// Scoreboard bench for bcd_char_ser; expected characters are queued at start.
module tb_bcd_char_ser;

  logic        clk_rx;
  logic        rst_clk_rx_n;
  logic        start;
  logic [18:0] bcd_in;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        done;

  int          assertions;
  int          failures;
  logic [7:0]  exp_q[$];
  bit          prev_stall;
  logic [7:0]  prev_data;

  bcd_char_ser dut (
    .clk_rx       (clk_rx),
    .rst_clk_rx_n (rst_clk_rx_n),
    .start        (start),
    .bcd_in       (bcd_in),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk_rx = 1'b0;
  always #5 clk_rx = ~clk_rx;

  function automatic void push_msg(input logic [18:0] v);
    logic [3:0] d [5];
    int first;
    d[4] = {1'b0, v[18:16]};
    d[3] = v[15:12];
    d[2] = v[11:8];
    d[1] = v[7:4];
    d[0] = v[3:0];
    first = 4;
`ifdef BCD_CHAR_SER_LZ_SUPPRESS_EN
    first = 0;
    for (int i = 0; i < 5; i++) if (d[i] != 4'd0) first = i;
`endif
    for (int i = first; i >= 0; i--)
      exp_q.push_back((d[i] > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d[i]}));
    exp_q.push_back(8'h20);
  endfunction

  // Scoreboard monitor: compare every transferred character and check stall hold
  always @(negedge clk_rx) begin
    if (!rst_clk_rx_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        assertions++;
        if (char_valid !== 1'b1 || char_data !== prev_data) begin
          failures++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", char_valid, char_data, prev_data);
        end
      end
      if (char_valid === 1'b1 && char_ready === 1'b1) begin
        assertions++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_char: got %h, required none", char_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (char_data !== e) begin
            failures++;
            $display("FAIL char: got %h, required %h", char_data, e);
          end
        end
      end
      prev_stall = (char_valid === 1'b1) && (char_ready === 1'b0);
      prev_data  = char_data;
    end
  end

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_rx);
      if (done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_start(input logic [18:0] v);
    @(posedge clk_rx); #2;
    bcd_in = v;
    start  = 1'b1;
    push_msg(v);
    @(posedge clk_rx); #2;
    start  = 1'b0;
  endtask

  task automatic check_drained(input string name);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: %0d chars left, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic run_msg(input logic [18:0] v, input string name);
    bit ok;
    pulse_start(v);
    wait_done(60, ok);
    assertions++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%b, required 1", name, ok);
    end
    check_drained(name);
  endtask

  task automatic test_reset();
    rst_clk_rx_n = 1'b0;
    start = 1'b0; bcd_in = 19'h0; char_ready = 1'b1;
    #1;
    assertions++;
    if ({char_data, char_valid, busy, done} !== 11'h000) begin
      failures++;
      $display("FAIL reset: data=%h valid=%b busy=%b done=%b, required all 0", char_data, char_valid, busy, done);
    end
    repeat (2) @(posedge clk_rx);
    #2 rst_clk_rx_n = 1'b1;
    @(negedge clk_rx);
    assertions++;
    if ({char_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle: valid=%b busy=%b done=%b, required 0", char_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    pulse_start(19'h12345);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_rx);
      assertions++;
      if (char_valid !== (c <= 6) || busy !== (c <= 6) || done !== (c == 7)) begin
        failures++;
        $display("FAIL basic_timing c%0d: valid=%b busy=%b done=%b, required %b %b %b",
                 c, char_valid, busy, done, (c <= 6), (c <= 6), (c == 7));
      end
    end
    @(negedge clk_rx);
    assertions++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b, required 0", done);
    end
    check_drained("basic");
  endtask

  task automatic test_ready_toggle();
    bit seen;
    seen = 1'b0;
    pulse_start(19'h12345);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_rx);
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk_rx); #2;
      char_ready = ~char_ready;
    end
    char_ready = 1'b1;
    assertions++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL toggle_done: done seen=%b, required 1", seen);
    end
    check_drained("toggle");
  endtask

  task automatic test_leading_zeros();
    run_msg(19'h00042, "lz42");
    run_msg(19'h00000, "lz0");
  endtask

  task automatic test_illegal();
    run_msg(19'h0A00F, "illegal");
  endtask

  task automatic test_start_ignored();
    bit ok;
    pulse_start(19'h12345);
    push_msg(19'h60000);
    @(posedge clk_rx); #2;
    bcd_in = 19'h60000;
    start  = 1'b1;
    wait_done(40, ok);
    assertions++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done1: done=%b, required 1", ok);
    end
    @(negedge clk_rx);
    assertions++;
    if (busy !== 1'b0 || char_valid !== 1'b0) begin
      failures++;
      $display("FAIL fin_start: busy=%b valid=%b, required 0 0", busy, char_valid);
    end
    @(posedge clk_rx); #2;
    start = 1'b0;
    @(negedge clk_rx);
    assertions++;
    if (busy !== 1'b1 || char_valid !== 1'b1) begin
      failures++;
      $display("FAIL after_done_start: busy=%b valid=%b, required 1 1", busy, char_valid);
    end
    wait_done(40, ok);
    assertions++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done2: done=%b, required 1", ok);
    end
    check_drained("ignore");
  endtask

  task automatic test_async_reset();
    pulse_start(19'h12345);
    for (int i = 0; i < 20 && exp_q.size() > 4; i++) @(negedge clk_rx);
    @(posedge clk_rx); #2;
    rst_clk_rx_n = 1'b0;
    #1;
    assertions++;
    if ({char_data, char_valid, busy, done} !== 11'h000) begin
      failures++;
      $display("FAIL async_reset: data=%h valid=%b busy=%b done=%b, required all 0", char_data, char_valid, busy, done);
    end
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_rx);
      assertions++;
      if (done !== 1'b0 || char_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold c%0d: done=%b valid=%b, required 0 0", c, done, char_valid);
      end
    end
    @(posedge clk_rx); #2;
    rst_clk_rx_n = 1'b1;
    @(negedge clk_rx);
    assertions++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_done: done=%b, required 0", done);
    end
    run_msg(19'h12345, "after_reset");
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_leading_zeros();
    test_illegal();
    test_start_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
